// File: rtl/swerv_rvfi_aligner.sv
// In-order RVFI record builder for the SweRV EL2 trace bench.
// Retired loads wait in a ring buffer until their late writeback arrives.
module swerv_rvfi_aligner #(
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          ret_valid,
  input  logic [31:0]   ret_insn,
  input  logic [31:0]   ret_pc,
  input  logic [31:0]   ret_next_pc,
  input  logic [4:0]    ret_rs1_addr,
  input  logic [4:0]    ret_rs2_addr,
  input  logic [31:0]   ret_rs1_rdata,
  input  logic [31:0]   ret_rs2_rdata,
  input  logic [4:0]    ret_rd_addr,
  input  logic          ret_rd_wren,
  input  logic [31:0]   ret_rd_wdata,
  input  logic          ret_load_pending,
  input  logic [31:0]   ret_mem_addr,
  input  logic [31:0]   ret_mem_rdata,
  input  logic [31:0]   ret_mem_wdata,
  input  logic [3:0]    ret_mem_rmask,
  input  logic [3:0]    ret_mem_wmask,
  input  logic          late_wb_valid,
  input  logic [4:0]    late_wb_addr,
  input  logic [31:0]   late_wb_data,
  output logic          rvfi_valid,
  output logic          rvfi_rd_wren,
  output logic [31:0]   rvfi_insn,
  output logic [31:0]   rvfi_pc_rdata,
  output logic [31:0]   rvfi_pc_wdata,
  output logic [31:0]   rvfi_rs1_rdata,
  output logic [31:0]   rvfi_rs2_rdata,
  output logic [31:0]   rvfi_rd_wdata,
  output logic [31:0]   rvfi_mem_addr,
  output logic [31:0]   rvfi_mem_rdata,
  output logic [31:0]   rvfi_mem_wdata,
  output logic [4:0]    rvfi_rs1_addr,
  output logic [4:0]    rvfi_rs2_addr,
  output logic [4:0]    rvfi_rd_addr,
  output logic [3:0]    rvfi_mem_rmask,
  output logic [3:0]    rvfi_mem_wmask,
  output logic [AW:0]   occupancy,
  output logic          overflow_o,
  output logic          orphan_wb_o
);

  typedef struct packed {
    logic [31:0] insn;
    logic [31:0] pc;
    logic [31:0] npc;
    logic [4:0]  rs1a;
    logic [4:0]  rs2a;
    logic [31:0] rs1d;
    logic [31:0] rs2d;
    logic [4:0]  rda;
    logic        wren;
    logic [31:0] wdata;
    logic [31:0] maddr;
    logic [31:0] mrdata;
    logic [31:0] mwdata;
    logic [3:0]  rmask;
    logic [3:0]  wmask;
    logic        pend;
  } ent_t;

  ent_t          mem_q [DEPTH];
  ent_t          push_e;
  ent_t          head_e;
  logic [AW:0]   head_q, tail_q;
  logic [AW:0]   count;
  logic          empty, full;
  logic          pop, push, drop;
  logic          mfound;
  logic [AW-1:0] midx;

  assign count  = tail_q - head_q;
  assign empty  = (count == '0);
  assign full   = (count == (AW+1)'(DEPTH));
  assign head_e = mem_q[head_q[AW-1:0]];
  assign pop    = !empty && !head_e.pend;
  assign push   = ret_valid && (!full || pop);
  assign drop   = ret_valid && full && !pop;

  assign occupancy = count;

  always_comb begin
    push_e        = '0;
    push_e.insn   = ret_insn;
    push_e.pc     = ret_pc;
    push_e.npc    = ret_next_pc;
    push_e.rs1a   = ret_rs1_addr;
    push_e.rs2a   = ret_rs2_addr;
    push_e.rs1d   = ret_rs1_rdata;
    push_e.rs2d   = ret_rs2_rdata;
    push_e.rda    = ret_rd_addr;
    push_e.wren   = ret_rd_wren;
    push_e.wdata  = ret_load_pending ? 32'h0 : ret_rd_wdata;
    push_e.maddr  = ret_mem_addr;
    push_e.mrdata = ret_mem_rdata;
    push_e.mwdata = ret_mem_wdata;
    push_e.rmask  = ret_mem_rmask;
    push_e.wmask  = ret_mem_wmask;
    push_e.pend   = ret_load_pending && ret_rd_wren
                    && (ret_rd_addr != 5'd0);
  end

  // Oldest-first scan over entries held at the start of the cycle
  always_comb begin
    mfound = 1'b0;
    midx   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!mfound && i < int'(count)
          && mem_q[head_q[AW-1:0] + AW'(i)].pend
          && mem_q[head_q[AW-1:0] + AW'(i)].rda == late_wb_addr) begin
        mfound = 1'b1;
        midx   = head_q[AW-1:0] + AW'(i);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      head_q      <= '0;
      tail_q      <= '0;
      overflow_o  <= 1'b0;
      orphan_wb_o <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (late_wb_valid) begin
        if (mfound) begin
          mem_q[midx].wdata <= late_wb_data;
          mem_q[midx].pend  <= 1'b0;
        end else begin
          orphan_wb_o <= 1'b1;
        end
      end
      if (push) begin
        mem_q[tail_q[AW-1:0]] <= push_e;
        tail_q <= tail_q + 1'b1;
      end
      if (pop) head_q <= head_q + 1'b1;
      if (drop) overflow_o <= 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rvfi_valid     <= 1'b0;
      rvfi_rd_wren   <= 1'b0;
      rvfi_insn      <= '0;
      rvfi_pc_rdata  <= '0;
      rvfi_pc_wdata  <= '0;
      rvfi_rs1_rdata <= '0;
      rvfi_rs2_rdata <= '0;
      rvfi_rd_wdata  <= '0;
      rvfi_mem_addr  <= '0;
      rvfi_mem_rdata <= '0;
      rvfi_mem_wdata <= '0;
      rvfi_rs1_addr  <= '0;
      rvfi_rs2_addr  <= '0;
      rvfi_rd_addr   <= '0;
      rvfi_mem_rmask <= '0;
      rvfi_mem_wmask <= '0;
    end else begin
      rvfi_valid <= pop;
      if (pop) begin
        rvfi_rd_wren   <= head_e.wren;
        rvfi_insn      <= head_e.insn;
        rvfi_pc_rdata  <= head_e.pc;
        rvfi_pc_wdata  <= head_e.npc;
        rvfi_rs1_rdata <= head_e.rs1d;
        rvfi_rs2_rdata <= head_e.rs2d;
        rvfi_rd_wdata  <= head_e.wdata;
        rvfi_mem_addr  <= head_e.maddr;
        rvfi_mem_rdata <= head_e.mrdata;
        rvfi_mem_wdata <= head_e.mwdata;
        rvfi_rs1_addr  <= head_e.rs1a;
        rvfi_rs2_addr  <= head_e.rs2a;
        rvfi_rd_addr   <= head_e.rda;
        rvfi_mem_rmask <= head_e.rmask;
        rvfi_mem_wmask <= head_e.wmask;
      end
    end
  end

endmodule
